coproc_scheduler: RTL and testbench

Command scheduler and memory-port owner for the matrix coprocessor. Queues host instruction words in a small FIFO and writes each one to instruction address 0 of the shared 256x16 memory. It then pulses the coprocessor start, waits for completion or timeout, and reports a status code. It also multiplexes the single memory port between direct host accesses and the running coprocessor.

---
 rtl/coproc_pkg.sv | 18 +
 rtl/sync_fifo.sv | 41 ++++
 rtl/coproc_scheduler.sv | 107 ++++++++++
 tb/tb_coproc_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// coproc_pkg: shared types and constants for the coprocessor scheduler
package coproc_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] INSTR_ADDR_DFLT = 8'd0;
  localparam logic [1:0] STAT_OK = 2'b00;
  localparam logic [1:0] STAT_OVF = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  typedef enum logic [2:0] {
    IDLE,
    HOST_ACC,
    WR_INSTR,
    RD_SETTLE,
    START,
    WAIT_DONE,
    REPORT
  } state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and combinational head
module sync_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign rdata_o = mem_q[rp_q];
  assign count_o = cnt_q;
  // storage needs no reset; only pointers decide what is valid
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= wdata_i;
  // pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/coproc_scheduler.sv
// coproc_scheduler: instruction queue, coprocessor sequencing and memory port mux
module coproc_scheduler
  import coproc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter logic [7:0] INSTR_ADDR = INSTR_ADDR_DFLT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  input  logic [15:0]                     cmd_instr,
  output logic                            cmd_ready,
  input  logic                            host_req,
  input  logic                            host_we,
  input  logic [7:0]                      host_addr,
  input  logic [15:0]                     host_wdata,
  output logic                            host_ack,
  output logic [15:0]                     host_rdata,
  output logic                            cop_start,
  output logic                            cop_reset,
  input  logic                            cop_done,
  input  logic                            cop_overflow,
  input  logic [7:0]                      cop_addr,
  input  logic                            cop_wb,
  input  logic [15:0]                     cop_wdata,
  output logic [7:0]                      mem_addr,
  output logic                            mem_we,
  output logic [15:0]                     mem_wdata,
  input  logic [15:0]                     mem_rdata,
  output logic                            busy,
  output logic                            stat_valid,
  output logic [1:0]                      stat_code,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);
  state_e state_q, state_d;
  logic [DATA_W-1:0] instr_q, head;
  logic [CW-1:0] cnt_q;
  logic ovf_q, done_q, ack_q, abort_q;
  logic [1:0] code_q;
  logic full, empty, pop, host_go, done_edge, tmo, cop_mode, wait_st;
  // the ack cycle is back in IDLE while host_req is still high; ignore it there
  assign host_go = host_req && !ack_q;
  assign pop = state_q == IDLE && !host_go && !empty;
  assign wait_st = state_q == WAIT_DONE;
  assign done_edge = cop_done && !done_q;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES-1);
  assign cop_mode = state_q == START || wait_st;
  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(cmd_valid),
    .pop_i(pop),
    .wdata_i(cmd_instr),
    .rdata_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(fifo_count)
  );
  assign cmd_ready = !full;
  assign host_ack = ack_q;
  assign host_rdata = ack_q ? mem_rdata : '0;
  assign cop_start = state_q == START;
  assign cop_reset = abort_q;
  assign busy = state_q != IDLE;
  assign stat_valid = state_q == REPORT;
  assign stat_code = code_q;
  assign mem_addr = state_q == HOST_ACC ? host_addr : cop_mode ? cop_addr : INSTR_ADDR;
  assign mem_we = state_q == HOST_ACC ? host_we : state_q == WR_INSTR ? 1'b1 : cop_mode ? cop_wb : 1'b0;
  assign mem_wdata = state_q == HOST_ACC ? host_wdata : state_q == WR_INSTR ? instr_q : cop_mode ? cop_wdata : '0;
  // sequencing: host access beats queued work; done beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = host_go ? HOST_ACC : !empty ? WR_INSTR : IDLE;
      HOST_ACC:  state_d = IDLE;
      WR_INSTR:  state_d = RD_SETTLE;
      RD_SETTLE: state_d = START;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: state_d = (done_edge || tmo) ? REPORT : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  // state, run bookkeeping and registered pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      ack_q <= 1'b0;
      abort_q <= 1'b0;
      code_q <= STAT_OK;
    end else begin
      state_q <= state_d;
      done_q <= cop_done;
      ack_q <= state_q == HOST_ACC;
      abort_q <= wait_st && tmo && !done_edge;
      if (pop) instr_q <= head;
      cnt_q <= state_q == START ? '0 : wait_st ? cnt_q + CW'(1) : cnt_q;
      ovf_q <= state_q == START ? 1'b0 : ovf_q | (wait_st && cop_overflow);
      if (wait_st && (done_edge || tmo))
        code_q <= done_edge ? (ovf_q ? STAT_OVF : STAT_OK) : STAT_TIMEOUT;
    end
endmodule

// File: tb/tb_coproc_scheduler.sv
// tb_coproc_scheduler: directed checks of queueing, sequencing, timeout and host access
module tb_coproc_scheduler;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 0, host_req = 0, host_we = 0, cop_done = 0, cop_overflow = 0, cop_wb = 0;
  logic [15:0] cmd_instr = 0, host_wdata = 0, cop_wdata = 0, mem_rdata = 0;
  logic [7:0] host_addr = 0, cop_addr = 8'h55;
  logic cmd_ready, host_ack, cop_start, cop_reset, mem_we, busy, stat_valid;
  logic [15:0] host_rdata, mem_wdata;
  logic [7:0] mem_addr;
  logic [1:0] stat_code;
  logic [2:0] fifo_count;
  logic [15:0] mem [256];
  int total = 0, passed = 0;

  typedef struct {
    logic v;
    logic [15:0] instr;
    logic rdy;
    int cnt;
  } vec_t;
  vec_t tbl[6];

  coproc_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16), .INSTR_ADDR(8'd0)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_instr(cmd_instr), .cmd_ready(cmd_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .cop_start(cop_start), .cop_reset(cop_reset),
    .cop_done(cop_done), .cop_overflow(cop_overflow), .cop_addr(cop_addr), .cop_wb(cop_wb),
    .cop_wdata(cop_wdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .stat_valid(stat_valid), .stat_code(stat_code),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask

  // starts in an IDLE cycle where the head is being popped; ends in the following IDLE cycle
  task automatic run_cmd(input logic [15:0] ins, input int cnt, input logic ovf, input logic [1:0] code);
    tick;
    chk("wr_we", mem_we, 1);
    chk("wr_data", mem_wdata, ins);
    chk("wr_count", fifo_count, cnt);
    tick;
    tick;
    chk("run_start", cop_start, 1);
    tick;
    cop_overflow = ovf;
    tick;
    cop_overflow = 0;
    cop_done = 1;
    tick;
    chk("run_stat_valid", stat_valid, 1);
    chk("run_stat_code", stat_code, code);
    cop_done = 0;
    tick;
  endtask

  initial begin
    tbl[0] = '{1'b1, 16'h0102, 1'b1, 1};
    tbl[1] = '{1'b1, 16'h0103, 1'b1, 2};
    tbl[2] = '{1'b1, 16'h0104, 1'b1, 3};
    tbl[3] = '{1'b1, 16'h0105, 1'b1, 4};
    tbl[4] = '{1'b1, 16'h0106, 1'b0, 4};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 4};
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pulses", {host_ack, cop_start, cop_reset, stat_valid}, 0);
    chk("rst_code", stat_code, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_mem", {mem_we, mem_addr}, 0);
    reset = 0;
    tick;
    // single command, done edge after ten cycles of waiting
    cmd_valid = 1;
    cmd_instr = 16'h0019;
    tick;
    cmd_valid = 0;
    chk("t1_count1", fifo_count, 1);
    tick;
    chk("t1_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h00, 16'h0019});
    chk("t1_nostart_wr", cop_start, 0);
    tick;
    chk("t1_settle", {mem_we, mem_addr, cop_start}, 0);
    tick;
    chk("t1_start", cop_start, 1);
    chk("t1_instr_rd", mem_rdata, 16'h0019);
    chk("t1_cop_mux", mem_addr, 8'h55);
    tick;
    chk("t1_start_once", cop_start, 0);
    repeat (10) tick;
    chk("t1_no_stat", stat_valid, 0);
    cop_done = 1;
    tick;
    chk("t1_stat", {stat_valid, stat_code, cop_reset}, {1'b1, 2'b00, 1'b0});
    cop_done = 0;
    tick;
    chk("t1_idle", {busy, stat_valid}, 0);
    // timeout run while the queue is filled to capacity
    cmd_valid = 1;
    cmd_instr = 16'h0101;
    tick;
    cmd_valid = 0;
    tick;
    tick;
    tick;
    tick;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = tbl[i].v;
      cmd_instr = tbl[i].instr;
      chk("fill_ready", cmd_ready, tbl[i].rdy);
      tick;
      chk("fill_count", fifo_count, tbl[i].cnt);
    end
    cmd_valid = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      chk("tmo_wait", {busy, stat_valid, cop_reset}, 3'b100);
    end
    tick;
    chk("tmo_report", {stat_valid, stat_code, cop_reset}, {1'b1, 2'b10, 1'b1});
    tick;
    chk("tmo_reset_once", cop_reset, 0);
    chk("tmo_code_held", stat_code, 2'b10);
    run_cmd(16'h0102, 3, 1'b0, 2'b00);
    run_cmd(16'h0103, 2, 1'b1, 2'b01);
    run_cmd(16'h0104, 1, 1'b0, 2'b00);
    run_cmd(16'h0105, 0, 1'b0, 2'b00);
    chk("drain_idle", {busy, fifo_count}, 0);
    // host write then host read racing a queued command
    host_req = 1;
    host_we = 1;
    host_addr = 8'h0E;
    host_wdata = 16'hBEEF;
    tick;
    chk("hw_mux", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h0E, 16'hBEEF});
    tick;
    chk("hw_ack", host_ack, 1);
    host_req = 0;
    host_we = 0;
    tick;
    chk("hw_ack_once", host_ack, 0);
    cmd_valid = 1;
    cmd_instr = 16'h0A5A;
    tick;
    cmd_valid = 0;
    host_req = 1;
    tick;
    chk("hr_prio", {fifo_count, mem_we, mem_addr}, {3'd1, 1'b0, 8'h0E});
    tick;
    chk("hr_ack", {host_ack, host_rdata}, {1'b1, 16'hBEEF});
    host_req = 0;
    host_addr = 8'h00;
    tick;
    chk("g_wr", mem_wdata, 16'h0A5A);
    tick;
    tick;
    chk("g_start", cop_start, 1);
    tick;
    host_req = 1;
    cop_overflow = 1;
    tick;
    cop_overflow = 0;
    chk("g_stall1", host_ack, 0);
    tick;
    chk("g_stall2", host_ack, 0);
    cop_done = 1;
    tick;
    chk("g_report", {stat_valid, stat_code, host_ack}, {1'b1, 2'b01, 1'b0});
    cop_done = 0;
    tick;
    chk("g_idle_noack", {busy, host_ack}, 0);
    tick;
    chk("g_hostacc", {busy, host_ack}, 2'b10);
    tick;
    chk("g_late_ack", {host_ack, host_rdata}, {1'b1, 16'h0A5A});
    host_req = 0;
    tick;
    // reset while waiting with two commands queued
    cmd_valid = 1;
    cmd_instr = 16'h0201;
    tick;
    cmd_instr = 16'h0202;
    tick;
    cmd_instr = 16'h0203;
    tick;
    cmd_valid = 0;
    tick;
    tick;
    chk("r_pre", {busy, fifo_count}, {1'b1, 3'd2});
    reset = 1;
    #1;
    chk("r_async", {busy, fifo_count, stat_code, cop_reset}, 0);
    tick;
    chk("r_held", {busy, cop_reset, cmd_ready}, 3'b001);
    reset = 0;
    tick;
    chk("r_after", {busy, fifo_count, cop_start}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
